// File: rtl/addpass_dp_arbiter.sv
// Round-robin arbiter sharing one combinational 3-bit add/pass datapath.
// Ports: clk, rst (async high); req_valid/req_ready/req_op/req_a/req_b per
// requester; dp_a/dp_b/dp_sel drive the datapath, dp_res returns its result;
// rsp_valid/rsp_ready/rsp_id/rsp_data carry the response; rsp_drop pulses
// when a stalled response is discarded.
module addpass_dp_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [3*NREQ-1:0] req_a,
  input  logic [3*NREQ-1:0] req_b,
  output logic [2:0]        dp_a,
  output logic [2:0]        dp_b,
  output logic              dp_sel,
  input  logic [3:0]        dp_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic              rsp_drop
);

  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_win;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [2:0]      w_a;
  logic [2:0]      w_b;
  logic            w_op;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_timeout;

  // First valid requester scanning upward from r_ptr with wrap.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_win = '0;
    w_a   = '0;
    w_b   = '0;
    w_op  = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_win = IDW'(idx);
        w_a   = req_a[3*idx +: 3];
        w_b   = req_b[3*idx +: 3];
        w_op  = req_op[idx];
      end
    end
  end

  assign w_ptr_nxt = (r_win == IDW'(NREQ - 1)) ? '0 : r_win + IDW'(1);
  assign w_cnt_inc = r_cnt + CW'(1);
  // The stall counter reaching HOLD_MAX on this cycle means timeout.
  assign w_timeout = (HOLD_MAX > 0) && (w_cnt_inc == CW'(HOLD_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_cnt     <= '0;
      req_ready <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_sel    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_drop  <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_drop  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_win     <= w_win;
            dp_a      <= w_a;
            dp_b      <= w_b;
            dp_sel    <= w_op;
            req_ready <= NREQ'(1) << w_win;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rsp_data  <= dp_res;
          rsp_id    <= r_win;
          rsp_valid <= 1'b1;
          r_ptr     <= w_ptr_nxt;
          r_cnt     <= '0;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_cnt     <= '0;
            // Back-to-back: arbitrate with the already advanced pointer.
            if (w_any) begin
              r_win     <= w_win;
              dp_a      <= w_a;
              dp_b      <= w_b;
              dp_sel    <= w_op;
              req_ready <= NREQ'(1) << w_win;
              r_state   <= S_ISSUE;
            end else begin
              r_state   <= S_IDLE;
            end
          end else if (w_timeout) begin
            rsp_valid <= 1'b0;
            rsp_drop  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addpass_dp_arbiter.sv
// Directed testbench for addpass_dp_arbiter.
// Models the shared add/pass datapath and checks grants and responses.
module tb_addpass_dp_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [3*NREQ-1:0] req_a;
  logic [3*NREQ-1:0] req_b;
  logic [2:0]        dp_a;
  logic [2:0]        dp_b;
  logic              dp_sel;
  logic [3:0]        dp_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_data;
  logic              rsp_drop;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign dp_res = dp_sel ? ({1'b0, dp_a} + {1'b0, dp_b}) : {1'b0, dp_a};

  addpass_dp_arbiter #(
    .NREQ(NREQ),
    .IDW(IDW),
    .HOLD_MAX(15)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .dp_a(dp_a),
    .dp_b(dp_b),
    .dp_sel(dp_sel),
    .dp_res(dp_res),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_drop(rsp_drop)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op,
                         input logic [2:0] a, input logic [2:0] b);
    req_op[i]       = op;
    req_a[3*i +: 3] = a;
    req_b[3*i +: 3] = b;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) step();
    check("reset", {req_ready, dp_a, dp_b, dp_sel, rsp_valid,
                    rsp_id, rsp_data, rsp_drop}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int g;

    // 1: single add request with carry
    do_reset();
    set_req(2, 1'b1, 3'd5, 3'd6);
    req_valid = 4'b0100;
    check("t1_idle_ready", req_ready, 0);
    step();
    check("t1_ready", req_ready, 4'b0100);
    check("t1_dp", {dp_sel, dp_a, dp_b}, {1'b1, 3'd5, 3'd6});
    check("t1_noval", rsp_valid, 0);
    req_valid = '0;
    step();
    check("t1_valid", rsp_valid, 1);
    check("t1_data", rsp_data, 4'b1011);
    check("t1_id", rsp_id, 2);
    check("t1_ready_low", req_ready, 0);
    rsp_ready = 1'b1;
    step();
    check("t1_done", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 2: all requesters, round-robin with wrap
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 3'(i + 1), 3'(i));
    req_valid = 4'hf;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      step();
      check("t2_grant", req_ready, 32'd1 << g);
      step();
      if (k == 4) req_valid = '0;
      check("t2_id", rsp_id, g);
      check("t2_data", rsp_data, 2 * g + 1);
    end
    step();
    check("t2_idle", rsp_valid, 0);
    rsp_ready = 1'b0;

    // 3: pass operation ignores B
    do_reset();
    set_req(1, 1'b0, 3'd7, 3'd3);
    req_valid = 4'b0010;
    step();
    check("t3_ready", req_ready, 4'b0010);
    req_valid = '0;
    step();
    check("t3_data", rsp_data, 4'b0111);
    check("t3_id", rsp_id, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // 4a: stall timeout
    do_reset();
    set_req(0, 1'b1, 3'd3, 3'd4);
    set_req(1, 1'b1, 3'd1, 3'd1);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rsp_valid) n++;
      else break;
    end
    check("t4_hold_cycles", n, 15);
    check("t4_drop", rsp_drop, 1);
    req_valid = 4'b0010;
    step();
    check("t4_drop_pulse", rsp_drop, 0);
    check("t4_idle_regrant", req_ready, 4'b0010);
    req_valid = '0;
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // 4b: accept on the timeout cycle
    do_reset();
    set_req(0, 1'b1, 3'd3, 3'd4);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) n++;
    end
    check("t4b_hold_cycles", n, 15);
    rsp_ready = 1'b1;
    step();
    check("t4b_accept", rsp_valid, 0);
    check("t4b_nodrop", rsp_drop, 0);
    rsp_ready = 1'b0;

    // 5: async reset in RESP
    do_reset();
    set_req(2, 1'b1, 3'd2, 3'd2);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    step();
    check("t5_valid", rsp_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t5_async", {rsp_valid, rsp_id, rsp_data}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 3'(i), 3'(i));
    req_valid = 4'hf;
    step();
    check("t5_ptr0", req_ready, 4'b0001);
    req_valid = '0;
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // 6: requester 1 withdraws and is skipped
    do_reset();
    set_req(0, 1'b1, 3'd1, 3'd1);
    set_req(1, 1'b1, 3'd2, 3'd2);
    set_req(2, 1'b1, 3'd3, 3'd3);
    req_valid = 4'b0011;
    step();
    check("t6_grant0", req_ready, 4'b0001);
    req_valid = 4'b0100;
    step();
    check("t6_id0", rsp_id, 0);
    check("t6_data0", rsp_data, 2);
    rsp_ready = 1'b1;
    step();
    check("t6_skip", req_ready, 4'b0100);
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    check("t6_id2", rsp_id, 2);
    check("t6_data2", rsp_data, 6);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
